// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - drives all four {a,b} vectors into a gate block and checks its five results
module gate_test_sequencer #(
  parameter int unsigned HOLD = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       an_i,
  input  logic       o_i,
  input  logic       nt_i,
  input  logic       xr_i,
  input  logic       xnr_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec,
  output logic [4:0] fail_gate
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Last hold-count value before DRIVE hands over to CHECK.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_vec;
  logic [7:0] r_hold;
  logic       r_a;
  logic       r_b;
  logic [2:0] r_err_cnt;
  logic [3:0] r_fail_vec;
  logic [4:0] r_fail_gate;

  logic       w_hold_done;
  logic       w_last_vec;
  logic [4:0] w_expect;
  logic [4:0] w_actual;
  logic [4:0] w_mismatch;
  logic       w_any_mismatch;

  assign w_hold_done    = (r_hold == HOLD_LAST);
  assign w_last_vec     = (r_vec == 2'd3);
  // Gate order everywhere is {an, o, nt, xr, xnr}, an in the MSB.
  assign w_expect       = {r_a & r_b, r_a | r_b, ~r_a, r_a ^ r_b, ~(r_a ^ r_b)};
  assign w_actual       = {an_i, o_i, nt_i, xr_i, xnr_i};
  assign w_mismatch     = w_expect ^ w_actual;
  assign w_any_mismatch = |w_mismatch;

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: start is only looked at in IDLE/DONE, so a held start cannot restart a busy run.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DRIVE;
      S_DRIVE: if (w_hold_done) w_next = S_CHECK;
      S_CHECK: w_next = w_last_vec ? S_DONE : S_DRIVE;
      S_DONE:  if (start) w_next = S_DRIVE;
      default: w_next = S_IDLE;
    endcase
  end

  // Vector/hold counters, registered stimulus and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec       <= 2'd0;
      r_hold      <= 8'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_err_cnt   <= 3'd0;
      r_fail_vec  <= 4'd0;
      r_fail_gate <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_vec       <= 2'd0;
            r_hold      <= 8'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_err_cnt   <= 3'd0;
            r_fail_vec  <= 4'd0;
            r_fail_gate <= 5'd0;
          end
        end
        S_DRIVE: begin
          if (!w_hold_done) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        S_CHECK: begin
          if (w_any_mismatch) begin
            // Saturate: only four vectors exist, but never let the count wrap.
            if (r_err_cnt != 3'd4) begin
              r_err_cnt <= r_err_cnt + 3'd1;
            end
            r_fail_vec[r_vec] <= 1'b1;
            r_fail_gate       <= r_fail_gate | w_mismatch;
          end
          r_hold <= 8'd0;
          if (w_last_vec) begin
            r_a <= 1'b0;
            r_b <= 1'b0;
          end else begin
            r_vec        <= r_vec + 2'd1;
            {r_a, r_b}   <= r_vec + 2'd1;
          end
        end
        default: begin
          r_hold <= 8'd0;
        end
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = (r_state == S_DRIVE) || (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_err_cnt == 3'd0);
  assign err_cnt   = r_err_cnt;
  assign fail_vec  = r_fail_vec;
  assign fail_gate = r_fail_gate;

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 Parameter: HOLD, default 5, cycles each input vector is driven before sampling; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin test run; sampled in IDLE or DONE only.
REQ-005 a, b  output  1 each  registered stimulus driven into the gate block under test.
REQ-006 an_i, o_i, nt_i, xr_i, xnr_i  input  1 each  AND, OR, NOT(a), XOR, XNOR results returned from the gate block.
REQ-007 busy  output  1  high in DRIVE or CHECK.
REQ-008 done  output  1  high in DONE.
REQ-009 pass  output  1  high in DONE when err_cnt==0; low otherwise.
REQ-010 err_cnt  output  3  number of failing vectors, range 0..4.
REQ-011 fail_vec  output  4  bit k set when vector k ({a,b}=k) failed.
REQ-012 fail_gate  output  5  sticky per-gate mismatch mask {an,o,nt,xr,xnr}, bit 4 = an.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, CHECK, DONE.
REQ-014 IDLE: start=1 -> DRIVE; vec=0, hold count=0, err_cnt/fail_vec/fail_gate cleared on the same edge.
REQ-015 {a,b} SHALL equal vec (2-bit) in DRIVE and CHECK; a=b=0 in IDLE and DONE.
REQ-016 DRIVE SHALL last exactly HOLD cycles, then -> CHECK for exactly one cycle.
REQ-017 CHECK: expected an=a&b, o=a|b, nt=~a, xr=a^b, xnr=~(a^b); any inequality on a gate input = mismatch.
REQ-018 CHECK with >=1 mismatch: err_cnt+1, fail_vec[vec]=1, fail_gate |= mismatch mask, all on the CHECK-exit edge.
REQ-019 CHECK exit: vec<3 -> vec+1, DRIVE, hold count=0; vec==3 -> DONE.
REQ-020 Gate inputs SHALL be ignored outside CHECK.
REQ-021 Latency: done SHALL rise 4*(HOLD+1) edges after the edge sampling start (HOLD=5 -> 24).
REQ-022 start SHALL be ignored while busy=1.
REQ-023 DONE: outputs held stable until start=1 -> identical to IDLE start (results cleared, new run).
REQ-024 err_cnt SHALL never exceed 4 and never wrap.
REQ-025 busy, done mutually exclusive; pass SHALL never be high while done=0.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, a=b=0, busy=done=pass=0, err_cnt=0, fail_vec=0, fail_gate=0, vec=0, hold count=0.
REQ-027 rst SHALL take priority over start and over any in-progress run; no partial result survives.
REQ-028 After rst deasserts, a new start SHALL be required to begin a run.

Verification
REQ-029 Correct gate block, HOLD=5, start pulse -> a,b step 00,01,10,11 each held 6 cycles (5 DRIVE + 1 CHECK); done at edge 24; pass=1, err_cnt=0, fail_vec=0000, fail_gate=00000.
REQ-030 xr_i stuck at 0 -> failures on vectors 01,10; err_cnt=2, fail_vec=0110, fail_gate=00010, pass=0.
REQ-031 nt_i = a (not inverted) -> all 4 vectors fail; err_cnt=4, fail_vec=1111, fail_gate=00100.
REQ-032 rst asserted in DRIVE of vector 2 -> next cycle IDLE, all outputs 0; fresh start completes a full 4-vector run normally.
REQ-033 start held high through the run -> no restart while busy; run completes; with start still high in DONE, a new run begins next edge with results cleared.
REQ-034 HOLD=1 -> each vector 2 cycles; done at edge 8; results identical to REQ-029.
